// File: rtl/uart_dbg_pkg.sv
// Shared types and ASCII constants for the UART debug reply engine.
package uart_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SEND  = 2'd2,
    ST_TRAIL = 2'd3
  } state_e;

  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] QMARK    = 8'h3F;
  localparam logic [7:0] CMD_DUMP = 8'h41;
  localparam logic [7:0] DIGIT0   = 8'h30;

  // Byte/nibble position counter covers up to 8 positions (32-bit word in hex).
  localparam int unsigned CNT_W = 3;

  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return DIGIT0 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/hex_nibble_enc.sv
// Maps a 4-bit value to its uppercase ASCII hex character.
module hex_nibble_enc
  import uart_dbg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] ascii_o
);

  assign ascii_o = nib2ascii(nib_i);

endmodule

// File: rtl/uart_debug_port.sv
// Command decoder and reply serialiser for a byte-oriented debug link.
module uart_debug_port
  import uart_dbg_pkg::*;
#(
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned NUM_REGS = 8,
  parameter  int unsigned HEX_MODE = 1,
  localparam int unsigned ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              err_drop
);

  localparam int unsigned       STEP      = (HEX_MODE != 0) ? 4 : 8;
  localparam logic [CNT_W-1:0]  LAST_DATA = CNT_W'((HEX_MODE != 0) ? (DATA_W / 4 - 1) : (DATA_W / 8 - 1));
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [7:0]        UNK_BYTE  = (HEX_MODE != 0) ? QMARK : 8'h00;

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dump_q, dump_d;
  logic              unk_q, unk_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] shift_nxt;
  logic [7:0]        src_top;
  logic [7:0]        hex_chr;
  logic [7:0]        data_byte;
  logic [7:0]        rx_off;
  logic              is_read;
  logic [CNT_W-1:0]  last_pos;
  logic              done;

  assign shift_nxt = shift_q << STEP;
  // Next outgoing data comes from the register file on load, else from the shifted capture.
  assign src_top   = (state_q == ST_LOAD) ? reg_data[DATA_W-1 -: 8] : shift_nxt[DATA_W-1 -: 8];

  hex_nibble_enc u_enc (
    .nib_i   (src_top[7:4]),
    .ascii_o (hex_chr)
  );

  assign data_byte = (HEX_MODE != 0) ? hex_chr : src_top;
  assign rx_off    = cmd_q - DIGIT0;
  assign is_read   = (cmd_q >= DIGIT0) && (32'(rx_off) < NUM_REGS);
  assign last_pos  = unk_q ? '0 : LAST_DATA;

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    dump_d     = dump_q;
    unk_d      = unk_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    done       = 1'b0;

    // A command is latched one edge before the FSM acts on it; anything arriving
    // while a reply or a latched command is outstanding is dropped.
    pend_d = rx_valid && (state_q == ST_IDLE) && !pend_q;
    err_d  = rx_valid && !pend_d;
    if (pend_d) begin
      cmd_d = rx_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          if (is_read) begin
            addr_d = rx_off[ADDR_W-1:0];
            dump_d = 1'b0;
            unk_d  = 1'b0;
          end else if (cmd_q == CMD_DUMP) begin
            addr_d = '0;
            dump_d = 1'b1;
            unk_d  = 1'b0;
          end else begin
            dump_d = 1'b0;
            unk_d  = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        state_d    = ST_SEND;
        tx_valid_d = 1'b1;
        cnt_d      = '0;
        if (unk_q) begin
          shift_d   = '0;
          tx_data_d = UNK_BYTE;
        end else begin
          shift_d   = reg_data;
          tx_data_d = data_byte;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (cnt_q == last_pos) begin
            if (HEX_MODE != 0) begin
              state_d   = ST_TRAIL;
              cnt_d     = '0;
              tx_data_d = CR;
            end else begin
              done = 1'b1;
            end
          end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            shift_d   = shift_nxt;
            tx_data_d = data_byte;
          end
        end
      end
      ST_TRAIL: begin
        if (tx_ready) begin
          if (cnt_q == '0) begin
            cnt_d     = CNT_W'(1);
            tx_data_d = LF;
          end else begin
            done = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (done) begin
      tx_valid_d = 1'b0;
      cnt_d      = '0;
      if (dump_q && (addr_q != LAST_ADDR)) begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = ST_LOAD;
      end else begin
        state_d = ST_IDLE;
        dump_d  = 1'b0;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_q     <= 1'b0;
      cmd_q      <= '0;
      addr_q     <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      dump_q     <= 1'b0;
      unk_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      dump_q     <= dump_d;
      unk_q      <= unk_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      err_q      <= err_d;
    end
  end

  assign reg_addr = addr_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != ST_IDLE);
  assign err_drop = err_q;

endmodule

// File: doc/uart_debug_port.md
UART_DEBUG_PORT -- requirements
Module: uart_debug_port

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, register width in bits, a multiple of 8 and at most 32.
REQ-002 The block SHALL have parameter NUM_REGS, default 8, number of readable registers, from 1 to 10.
REQ-003 The block SHALL have parameter HEX_MODE, default 1: 1 = ASCII hex replies, 0 = raw binary replies.
REQ-004 The block SHALL have derived localparam ADDR_W = max(1, clog2(NUM_REGS)).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port rx_valid, input, 1 bit: one-cycle strobe, new byte received.
REQ-009 The block SHALL have port rx_data, input, 8 bits: received command byte, valid when rx_valid is high.
REQ-010 The block SHALL have port reg_addr, output, ADDR_W bits: register-file read address.
REQ-011 The block SHALL have port reg_data, input, DATA_W bits: register-file read data, combinational from reg_addr.
REQ-012 The block SHALL have port tx_valid, output, 1 bit: reply byte available.
REQ-013 The block SHALL have port tx_ready, input, 1 bit: transmitter accepts the byte.
REQ-014 The block SHALL have port tx_data, output, 8 bits: reply byte.
REQ-015 The block SHALL have port busy, output, 1 bit: a reply is in progress.
REQ-016 The block SHALL have port err_drop, output, 1 bit: one-cycle pulse when a command is discarded.

Function
REQ-017 The block SHALL implement FSM states IDLE, LOAD, SEND, TRAIL.
- IDLE -> LOAD on rx_valid.
- LOAD -> SEND after one cycle.
- SEND -> TRAIL (HEX_MODE=1) or to LOAD/IDLE (HEX_MODE=0) after the last data byte.
- TRAIL -> LOAD/IDLE after the LF byte.
REQ-018 The block SHALL recognise commands as follows:
- Read command: rx_data = 0x30+i with i < NUM_REGS reads register i.
- Dump command: rx_data = 0x41 ('A') dumps registers 0..NUM_REGS-1 in ascending order.
- Any other byte is unknown.
REQ-019 The block SHALL time a command as follows:
- rx_valid is sampled at edge k.
- reg_addr is valid throughout cycle k+1.
- reg_data is captured at edge k+2.
- tx_valid is first high after edge k+2.
REQ-020 In HEX_MODE=1 the block SHALL send DATA_W/4 uppercase hex characters, MSB nibble first, then 0x0D and 0x0A, for each register.
REQ-021 In HEX_MODE=0 the block SHALL send DATA_W/8 bytes per register, MSB byte first, with no trailer.
REQ-022 For an unknown command the block SHALL send 0x3F, 0x0D, 0x0A in HEX_MODE=1, or a single 0x00 in HEX_MODE=0.
REQ-023 A byte SHALL transfer on a cycle with tx_valid && tx_ready; while tx_valid && !tx_ready, tx_data SHALL be held stable.
REQ-024 tx_valid SHALL stay high between consecutive bytes of one reply when tx_ready is continuously high, giving one byte per cycle.
REQ-025 During a dump, after each register's final byte the FSM SHALL return to LOAD with reg_addr incremented; after register NUM_REGS-1 it SHALL go to IDLE.
REQ-026 busy SHALL be high in every state except IDLE.
REQ-027 An rx_valid while busy=1 SHALL be ignored, and err_drop SHALL pulse high in the following cycle.
REQ-028 An rx_valid on the same edge that returns the FSM to IDLE SHALL be ignored and SHALL pulse err_drop.
REQ-029 reg_addr SHALL hold its last value when not in LOAD.

Reset
REQ-030 While rst is high at a clock edge, the block SHALL set:
- state = IDLE;
- tx_valid = 0;
- tx_data = 0x00;
- reg_addr = 0;
- busy = 0;
- err_drop = 0;
- shift and counter registers = 0.
REQ-031 A reset asserted mid-reply SHALL abort the reply; no further bytes of it SHALL be sent after reset is released.

Structure
REQ-032 Shared package uart_dbg_pkg SHALL hold:
- the FSM state enum;
- ASCII constants CR, LF, QMARK, CMD_DUMP, DIGIT0;
- constant function nib2ascii.
REQ-033 The block SHALL contain one sub-module, hex_nibble_enc, mapping 4 bits to the ASCII characters '0'-'9' and 'A'-'F'.
REQ-034 The block SHALL use one byte/nibble counter, sized for 8 positions (DATA_W/4 at DATA_W=32), and one DATA_W-bit capture shift register.

Verification
REQ-035 With HEX_MODE=1, DATA_W=8, reg3=0xA5: rx 0x33 -> tx 0x41, 0x35, 0x0D, 0x0A, and tx_valid is high 2 cycles after the rx_valid edge.
REQ-036 With HEX_MODE=0, DATA_W=16, reg2=0x1234: rx 0x32 -> tx 0x12, 0x34, then busy is 0.
REQ-037 With HEX_MODE=1: rx 0x78 -> tx 0x3F, 0x0D, 0x0A; with HEX_MODE=0: rx 0x78 -> a single 0x00.
REQ-038 With NUM_REGS=4, HEX_MODE=1, regs={0x01,0x02,0x03,0x04}: rx 0x41 -> "01\r\n02\r\n03\r\n04\r\n" (16 bytes) in order.
REQ-039 With tx_ready held low for 5 cycles mid-reply: tx_data and tx_valid are held, and no byte is lost or duplicated.
REQ-040 A second rx_valid during a reply -> an err_drop pulse and an unchanged reply; rst during the 2nd byte -> tx_valid=0 the next cycle, then a clean IDLE.
